alu_scheduler: RTL

- Shares the single 16-bit ALU between two requesters: port 0 is the EX stage and port 1 is the branch/address unit.
- Arbitrates between them, latches the winning operation and drives the ALU control encoding (operation, Binvert, carryin).
- Registers the ALU result and returns it through a valid/ready response handshake.
- Sits between the control unit/requesters and the ALU instance in the CPU datapath.

---
 rtl/alu_scheduler.sv | 138 +++++++++++++
 1 files changed

// File: rtl/alu_scheduler.sv
// Two-port arbiter in front of the shared WIDTH-bit ALU: grants one requester,
// issues the latched op for one cycle, then holds the registered result until consumed.
module alu_scheduler #(
  parameter int WIDTH = 16,
  parameter bit FAIR  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid_0,
  input  logic             req_valid_1,
  output logic             req_ready_0,
  output logic             req_ready_1,
  input  logic [2:0]       req_op_0,
  input  logic [2:0]       req_op_1,
  input  logic [WIDTH-1:0] req_a_0,
  input  logic [WIDTH-1:0] req_b_0,
  input  logic [WIDTH-1:0] req_a_1,
  input  logic [WIDTH-1:0] req_b_1,
  output logic             rsp_valid_0,
  output logic             rsp_valid_1,
  input  logic             rsp_ready_0,
  input  logic             rsp_ready_1,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_operation,
  output logic             alu_binvert,
  output logic             alu_carryin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_RESP} state_t;

  state_t           r_state, w_next;
  logic             r_ptr, r_port;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_a, r_b;
  logic [WIDTH-1:0] r_rsp_result;
  logic             r_rsp_zero, r_rsp_err;

  logic             w_grant0, w_grant1, w_accept, w_illegal;
  logic [2:0]       w_sel_op;

  // Tie-break: round-robin pointer when FAIR, otherwise port 0 always wins.
  always_comb begin
    w_grant0 = 1'b0;
    w_grant1 = 1'b0;
    if (req_valid_0 && req_valid_1) begin
      if (FAIR && r_ptr) w_grant1 = 1'b1;
      else               w_grant0 = 1'b1;
    end else begin
      w_grant0 = req_valid_0;
      w_grant1 = req_valid_1;
    end
  end

  assign w_accept  = (r_state == S_IDLE) && (req_valid_0 || req_valid_1);
  assign w_sel_op  = w_grant1 ? req_op_1 : req_op_0;
  assign w_illegal = w_sel_op[2] & w_sel_op[1];

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_illegal ? S_RESP : S_ISSUE;
      S_ISSUE: w_next = S_RESP;
      S_RESP:  if (r_port ? rsp_ready_1 : rsp_ready_0) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    req_ready_0   = (r_state == S_IDLE) && w_grant0;
    req_ready_1   = (r_state == S_IDLE) && w_grant1;
    rsp_valid_0   = (r_state == S_RESP) && !r_port;
    rsp_valid_1   = (r_state == S_RESP) &&  r_port;
    alu_a         = '0;
    alu_b         = '0;
    alu_operation = 3'b100;
    alu_binvert   = 1'b1;
    alu_carryin   = 1'b0;
    if (r_state == S_ISSUE) begin
      alu_a = r_a;
      alu_b = r_b;
      case (r_op)
        3'd1: begin alu_binvert = 1'b0; alu_carryin = 1'b1; end
        3'd2: alu_operation = 3'b000;
        3'd3: alu_operation = 3'b001;
        3'd4: alu_operation = 3'b010;
        3'd5: alu_operation = 3'b011;
        default: alu_operation = 3'b100;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= 1'b0;
      r_port       <= 1'b0;
      r_op         <= '0;
      r_a          <= '0;
      r_b          <= '0;
      r_rsp_result <= '0;
      r_rsp_zero   <= 1'b0;
      r_rsp_err    <= 1'b0;
    end else begin
      if (w_accept) begin
        r_port <= w_grant1;
        r_op   <= w_sel_op;
        r_a    <= w_grant1 ? req_a_1 : req_a_0;
        r_b    <= w_grant1 ? req_b_1 : req_b_0;
        if (FAIR) r_ptr <= ~w_grant1;
        if (w_illegal) begin
          r_rsp_result <= '0;
          r_rsp_zero   <= 1'b0;
          r_rsp_err    <= 1'b1;
        end
      end
      if (r_state == S_ISSUE) begin
        r_rsp_result <= alu_result;
        r_rsp_zero   <= alu_zero;
        r_rsp_err    <= 1'b0;
      end
    end
  end

  assign rsp_result = r_rsp_result;
  assign rsp_zero   = r_rsp_zero;
  assign rsp_err    = r_rsp_err;

endmodule
